// File: rtl/ps2_host_tx_ctrl.sv
// PS/2 host-to-device byte transmitter: request-to-send, bit shifting, ACK check, timeouts.
// Define PS2_HOST_TX_RESEND_EN to resend up to MAX_RETRY times after a failure.
module ps2_host_tx_ctrl #(
   parameter int CLK_FREQ_KHZ     = 40000,
   parameter int INHIBIT_US       = 101,
   parameter int START_TIMEOUT_MS = 15,
   parameter int XFER_TIMEOUT_MS  = 2,
   parameter int MAX_RETRY        = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] the_command,
   input  logic       send_command,
   input  logic       ps2_clk_posedge,
   input  logic       ps2_clk_negedge,
   input  logic       ps2_dat_in,
   inout  wire        PS2_CLK,
   inout  wire        PS2_DAT,
   output logic       busy,
   output logic       command_was_sent,
   output logic       error_communication_timed_out,
   output logic [1:0] error_code,
   output logic [2:0] retry_count
);

   localparam int INH_CYC   = CLK_FREQ_KHZ * INHIBIT_US / 1000;
   localparam int START_CYC = CLK_FREQ_KHZ * START_TIMEOUT_MS;
   localparam int XFER_CYC  = CLK_FREQ_KHZ * XFER_TIMEOUT_MS;
   localparam int MAX_A     = (START_CYC > XFER_CYC) ? START_CYC : XFER_CYC;
   localparam int CNT_MAX   = (MAX_A > INH_CYC) ? MAX_A : INH_CYC;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);

   typedef logic [CNT_W-1:0] cnt_t;
   localparam cnt_t INH_C    = cnt_t'(INH_CYC);
   localparam cnt_t INH_HALF = cnt_t'(INH_CYC / 2);
   localparam cnt_t START_C  = cnt_t'(START_CYC);
   localparam cnt_t XFER_C   = cnt_t'(XFER_CYC);
   localparam cnt_t CNT_ONE  = cnt_t'(1);

`ifdef PS2_HOST_TX_RESEND_EN
   localparam bit RESEND_EN = 1'b1;
`else
   localparam bit RESEND_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_REQ_START, S_XMIT, S_STOP, S_ACK, S_DONE, S_ERROR
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE = 2'b00, ERR_START = 2'b01, ERR_XFER = 2'b10, ERR_NACK = 2'b11
   } err_t;

   state_t     state_q, state_d;
   cnt_t       cnt_q, cnt_d;
   logic [3:0] bit_q, bit_d;
   logic [8:0] shreg_q, shreg_d;
   logic [2:0] retry_q, retry_d;
   logic       ack_q, ack_d;
   logic       sent_q, sent_d;
   logic       err_flag_q, err_flag_d;
   err_t       err_code_q, err_code_d;

   logic       fail;
   err_t       fail_code;
   logic       clk_low, dat_oe, dat_out;
   cnt_t       xfer_tick;
   logic       xfer_expired;

   // NOTE: next-state logic assigns every variable a default first so no latches are inferred; the flops below use non-blocking updates only.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      shreg_d    = shreg_q;
      retry_d    = retry_q;
      ack_d      = ack_q;
      sent_d     = sent_q;
      err_flag_d = err_flag_q;
      err_code_d = err_code_q;
      fail       = 1'b0;
      fail_code  = ERR_NONE;
      clk_low    = 1'b0;
      dat_oe     = 1'b0;
      dat_out    = 1'b0;
      xfer_tick  = (cnt_q < XFER_C) ? cnt_q + CNT_ONE : cnt_q;
      // A device edge in the timeout cycle takes priority; the saturated counter re-fires next cycle.
      xfer_expired = (cnt_q == XFER_C) && !ps2_clk_negedge && !ps2_clk_posedge;

      unique case (state_q)
         S_IDLE: begin
            shreg_d = {~^the_command, the_command};
            if (send_command) begin
               state_d = S_INHIBIT;
               cnt_d   = CNT_ONE;
               retry_d = '0;
            end
         end
         S_INHIBIT: begin
            clk_low = 1'b1;
            dat_oe  = (cnt_q >= INH_HALF);
            cnt_d   = cnt_q + CNT_ONE;
            if (!send_command) begin
               state_d = S_IDLE;
            end else if (cnt_q == INH_C) begin
               state_d = S_REQ_START;
               cnt_d   = CNT_ONE;
            end
         end
         S_REQ_START: begin
            dat_oe = 1'b1;
            cnt_d  = cnt_q + CNT_ONE;
            if (ps2_clk_negedge) begin
               state_d = S_XMIT;
               bit_d   = 4'd0;
               cnt_d   = CNT_ONE;
            end else if (cnt_q == START_C) begin
               fail      = 1'b1;
               fail_code = ERR_START;
            end
         end
         S_XMIT: begin
            dat_oe  = 1'b1;
            dat_out = shreg_q[bit_q];
            cnt_d   = xfer_tick;
            if (ps2_clk_negedge) begin
               if (bit_q == 4'd8) state_d = S_STOP;
               else               bit_d   = bit_q + 4'd1;
            end else if (xfer_expired) begin
               fail      = 1'b1;
               fail_code = ERR_XFER;
            end
         end
         S_STOP: begin
            cnt_d = xfer_tick;
            if (ps2_clk_negedge) begin
               state_d = S_ACK;
               ack_d   = 1'b0;
            end else if (xfer_expired) begin
               fail      = 1'b1;
               fail_code = ERR_XFER;
            end
         end
         S_ACK: begin
            cnt_d = xfer_tick;
            if (!ack_q && ps2_clk_negedge) begin
               if (ps2_dat_in) begin
                  fail      = 1'b1;
                  fail_code = ERR_NACK;
               end else begin
                  ack_d = 1'b1;
               end
            end else if (ack_q && ps2_clk_posedge) begin
               state_d    = S_DONE;
               sent_d     = 1'b1;
               err_code_d = ERR_NONE;
            end else if (xfer_expired) begin
               fail      = 1'b1;
               fail_code = ERR_XFER;
            end
         end
         S_DONE, S_ERROR: begin
            if (!send_command) begin
               state_d    = S_IDLE;
               sent_d     = 1'b0;
               err_flag_d = 1'b0;
               err_code_d = ERR_NONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (fail) begin
         if (RESEND_EN && (retry_q < 3'(MAX_RETRY))) begin
            retry_d = retry_q + 3'd1;
            state_d = S_INHIBIT;
            cnt_d   = CNT_ONE;
         end else begin
            state_d    = S_ERROR;
            err_flag_d = 1'b1;
            err_code_d = fail_code;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         shreg_q    <= '0;
         retry_q    <= '0;
         ack_q      <= 1'b0;
         sent_q     <= 1'b0;
         err_flag_q <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shreg_q    <= shreg_d;
         retry_q    <= retry_d;
         ack_q      <= ack_d;
         sent_q     <= sent_d;
         err_flag_q <= err_flag_d;
         err_code_q <= err_code_d;
      end
   end

   assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
   assign PS2_DAT = dat_oe ? dat_out : 1'bz;

   assign busy                          = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
   assign command_was_sent              = sent_q;
   assign error_communication_timed_out = err_flag_q;
   assign error_code                    = err_code_q;
   assign retry_count                   = retry_q;

endmodule

// File: tb/tb_ps2_host_tx_ctrl.sv
// Directed bench for ps2_host_tx_ctrl: normal send, start timeout, NACK, transfer timeout, abort, reset.
// Scaled timing: 4000 kHz, 1 ms timeouts -> inhibit 404 cycles, start/transfer timeouts 4000 cycles.
module tb_ps2_host_tx_ctrl;

   localparam int INH_CYC  = 404;   // 4000*101/1000
   localparam int HALF_CYC = 202;
   localparam int TO_CYC   = 4000;  // 4000 kHz * 1 ms
`ifdef PS2_HOST_TX_RESEND_EN
   localparam int EXP_RETRIES = 2;
`else
   localparam int EXP_RETRIES = 0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] the_command = 8'h00;
   logic       send_command = 1'b0;
   logic       ps2_clk_posedge = 1'b0;
   logic       ps2_clk_negedge = 1'b0;
   logic       ps2_dat_in = 1'b1;
   wire        ps2_clk_w;
   wire        ps2_dat_w;
   logic       busy, command_was_sent, error_communication_timed_out;
   logic [1:0] error_code;
   logic [2:0] retry_count;

   pullup (ps2_clk_w);
   pullup (ps2_dat_w);

   ps2_host_tx_ctrl #(
      .CLK_FREQ_KHZ(4000), .INHIBIT_US(101), .START_TIMEOUT_MS(1),
      .XFER_TIMEOUT_MS(1), .MAX_RETRY(2)
   ) dut (
      .clk(clk), .reset(reset), .the_command(the_command), .send_command(send_command),
      .ps2_clk_posedge(ps2_clk_posedge), .ps2_clk_negedge(ps2_clk_negedge),
      .ps2_dat_in(ps2_dat_in), .PS2_CLK(ps2_clk_w), .PS2_DAT(ps2_dat_w),
      .busy(busy), .command_was_sent(command_was_sent),
      .error_communication_timed_out(error_communication_timed_out),
      .error_code(error_code), .retry_count(retry_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic strobe(input bit is_neg);
      if (is_neg) ps2_clk_negedge = 1'b1;
      else        ps2_clk_posedge = 1'b1;
      tick();
      ps2_clk_negedge = 1'b0;
      ps2_clk_posedge = 1'b0;
   endtask

   // Counts consecutive observed cycles with PS2_CLK low, noting the first with PS2_DAT low.
   task automatic measure_inhibit(output int low_cnt, output int dat_first);
      low_cnt   = 0;
      dat_first = 0;
      while (ps2_clk_w == 1'b0 && low_cnt < 2000) begin
         low_cnt++;
         if (dat_first == 0 && ps2_dat_w == 1'b0) dat_first = low_cnt;
         tick();
      end
   endtask

   // Device side of one frame starting from REQ_START; ends right after the ACK-sample edge.
   task automatic run_frame(input logic ack_val, output logic [8:0] frame, output logic stop_rel);
      for (int i = 0; i < 9; i++) begin
         strobe(1'b1);
         frame[i] = ps2_dat_w;
         idle(2);
      end
      strobe(1'b1);
      stop_rel = ps2_dat_w;
      idle(2);
      strobe(1'b1);
      idle(2);
      ps2_dat_in = ack_val;
      strobe(1'b1);
      ps2_dat_in = 1'b1;
   endtask

   logic [8:0] frame;
   logic       stop_rel;
   int         low_cnt, dat_first, n;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      idle(3);
      check("rst_busy", busy, 0);
      check("rst_sent", command_was_sent, 0);
      check("rst_err", error_communication_timed_out, 0);
      check("rst_code", error_code, 0);
      check("rst_retry", retry_count, 0);
      check("rst_clk_rel", ps2_clk_w, 1);
      check("rst_dat_rel", ps2_dat_w, 1);
      reset = 1'b0;
      idle(2);

      // Normal send of 0xF4 with ACK
      the_command  = 8'hF4;
      send_command = 1'b1;
      tick();
      measure_inhibit(low_cnt, dat_first);
      check("ok_inh_len", low_cnt, INH_CYC);
      check("ok_dat_low_at", dat_first, HALF_CYC);
      check("ok_req_busy", busy, 1);
      check("ok_start_bit", ps2_dat_w, 0);
      run_frame(1'b0, frame, stop_rel);
      check("ok_frame", frame, {1'b0, 8'hF4});
      check("ok_stop_rel", stop_rel, 1);
      idle(2);
      strobe(1'b0);
      check("ok_sent", command_was_sent, 1);
      check("ok_code", error_code, 0);
      check("ok_retry", retry_count, 0);
      check("ok_err", error_communication_timed_out, 0);
      check("ok_busy", busy, 0);
      idle(3);
      check("ok_sent_held", command_was_sent, 1);
      send_command = 1'b0;
      tick();
      check("ok_sent_clr", command_was_sent, 0);
      check("ok_clk_rel", ps2_clk_w, 1);
      idle(2);

      // Device never clocks: start timeout(s)
      the_command  = 8'h55;
      send_command = 1'b1;
      n = 0;
      while (!error_communication_timed_out && n < 20000) begin
         tick();
         n++;
      end
      check("st_cycles", n, (EXP_RETRIES + 1) * (INH_CYC + TO_CYC) + 1);
      check("st_code", error_code, 2'b01);
      check("st_retry", retry_count, EXP_RETRIES);
      check("st_busy", busy, 0);
      check("st_clk_rel", ps2_clk_w, 1);
      check("st_dat_rel", ps2_dat_w, 1);
      send_command = 1'b0;
      tick();
      check("st_err_clr", error_communication_timed_out, 0);
      check("st_code_clr", error_code, 0);
      check("st_retry_held", retry_count, EXP_RETRIES);
      idle(2);

      // NACK on the first attempt, ACK on the resend
      the_command  = 8'h3C;
      send_command = 1'b1;
      tick();
      measure_inhibit(low_cnt, dat_first);
      run_frame(1'b1, frame, stop_rel);
      check("nk_frame", frame, {1'b1, 8'h3C});
`ifdef PS2_HOST_TX_RESEND_EN
      check("nk_retry1", retry_count, 1);
      measure_inhibit(low_cnt, dat_first);
      check("nk_inh_len2", low_cnt, INH_CYC);
      run_frame(1'b0, frame, stop_rel);
      check("nk_frame2", frame, {1'b1, 8'h3C});
      idle(2);
      strobe(1'b0);
      check("nk_sent", command_was_sent, 1);
      check("nk_code", error_code, 0);
      check("nk_retry", retry_count, 1);
`else
      check("nk_err", error_communication_timed_out, 1);
      check("nk_code", error_code, 2'b11);
      check("nk_retry", retry_count, 0);
      check("nk_sent", command_was_sent, 0);
`endif
      send_command = 1'b0;
      idle(3);

      // Device stops clocking after bit 4: transfer timeout(s)
      the_command  = 8'h12;
      send_command = 1'b1;
      for (int a = 0; a <= EXP_RETRIES; a++) begin
         if (a == 0) tick();
         measure_inhibit(low_cnt, dat_first);
         repeat (5) strobe(1'b1);
         n = 4;
         while (ps2_clk_w == 1'b1 && !error_communication_timed_out && n < 10000) begin
            tick();
            n++;
         end
         check("xt_cycles", n, TO_CYC);
      end
      check("xt_err", error_communication_timed_out, 1);
      check("xt_code", error_code, 2'b10);
      check("xt_retry", retry_count, EXP_RETRIES);
      check("xt_dat_rel", ps2_dat_w, 1);
      send_command = 1'b0;
      idle(3);

      // Abort during INHIBIT
      the_command  = 8'h99;
      send_command = 1'b1;
      idle(100);
      check("ab_inhibiting", ps2_clk_w, 0);
      send_command = 1'b0;
      tick();
      check("ab_clk_rel", ps2_clk_w, 1);
      check("ab_busy", busy, 0);
      check("ab_flags", {command_was_sent, error_communication_timed_out}, 0);
      idle(3);

      // Asynchronous reset in the middle of XMIT
      the_command  = 8'hF4;
      send_command = 1'b1;
      tick();
      measure_inhibit(low_cnt, dat_first);
      strobe(1'b1);
      idle(2);
      strobe(1'b1);
      check("ar_dat_driven", ps2_dat_w, 0);
      #1 reset = 1'b1;
      #1;
      check("ar_dat_rel", ps2_dat_w, 1);
      check("ar_clk_rel", ps2_clk_w, 1);
      check("ar_busy", busy, 0);
      send_command = 1'b0;
      idle(2);
      reset = 1'b0;
      idle(2);
      send_command = 1'b1;
      tick();
      measure_inhibit(low_cnt, dat_first);
      check("ar_inh_len", low_cnt, INH_CYC);
      run_frame(1'b0, frame, stop_rel);
      check("ar_frame", frame, {1'b0, 8'hF4});
      idle(2);
      strobe(1'b0);
      check("ar_sent", command_was_sent, 1);
      send_command = 1'b0;
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
